fu_out_buffer: RTL
==================

# fu_out_buffer

- Per-functional-unit output queue on the producer side of the FU-to-selector result interface.
- Accepts completed results from one FU pipeline and holds them in a small in-order ring.
- Presents the oldest result as an `FU_RS_PACKET` on the selector's `fu_rs[i]` input, and pops it only when that FU index is granted.
- One instance per FU slot, `FU_SIZE` instances total, placed between each ALU/LS/MULT/BEQ unit and the category-priority/round-robin result selector.

## Interface
Parameters:
- `DEPTH`, default 2: number of result entries, ≥1; any integer value, not restricted to powers of two.
- `FU_IDX`, default 0: this instance's slot in the selector's `fu_rs` array; compared against `fu_num`.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous active-high reset.
- `in_valid`  in  1  FU pipeline presents a completed result this cycle.
- `in_packet`  in  `FU_RS_PACKET`  completed result; its `.valid` field is ignored.
- `in_ready`  out  1  buffer can accept a result this cycle.
- `fu_num`  in  `$clog2(FU_SIZE)+1`  index chosen by the selector this cycle.
- `grant_valid`  in  1  selector's `fu_num` is a real grant (some `cat_select` bit set).
- `squash`  in  1  branch-mispredict flush; discard all held results.
- `fu_rs`  out  `FU_RS_PACKET`  head entry; `.valid` = 1 iff the buffer is presenting a result.
- `count`  out  `$clog2(DEPTH+1)`  number of occupied entries.

## Operation
- Storage: `DEPTH`-entry ring with `head`/`tail` pointers. Each pointer wraps to 0 after `DEPTH-1` via explicit compare, not modulo arithmetic. `count` is the occupancy.
- Granted: `grant = grant_valid && fu_num == FU_IDX && count != 0`. A grant received while empty is ignored and `count` is unchanged.
- Push: `push = in_valid && in_ready && !squash`. Writes `in_packet` at `tail`, then `tail` advances.
- Pop: `pop = grant && !squash`. `head` advances.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. A push into a full buffer is never possible because `in_ready` depends on `count` only.
- `in_ready = (count != DEPTH)`. It is a registered-state function with no combinational path from `fu_num` or `grant_valid`, which breaks the selector→FU loop.
- `fu_rs = storage[head]` with `.valid` forced to `(count != 0)`. Fields are don't-care when `.valid` = 0 but must be driven to a non-X value.
- Squash has priority over push and pop in the same cycle:
  - `count`, `head` and `tail` are cleared to 0.
  - A concurrent `in_valid` result is dropped.
- Results leave strictly in arrival order; no reordering and no duplication.

## Timing
- Reset values:
  - `count` = 0, `head` = `tail` = 0.
  - `fu_rs.valid` = 0.
  - `in_ready` = 1.
  - Storage contents are cleared to 0.
- Push latency: a result pushed at edge N appears on `fu_rs` in cycle N+1 when the buffer was empty. Otherwise it appears when it reaches the head.
- Pop: a grant in cycle N removes the head at edge N+1. The next entry, if any, is visible in cycle N+1, so back-to-back grants drain one result per cycle.
- Full boundary: with `count == DEPTH`, `in_ready` = 0 for the whole cycle, even if a grant arrives. `in_ready` rises in the cycle after the pop.
- Reset asserted mid-operation behaves like squash plus clearing of storage, and it overrides every other input.

## Configuration
- Macro `FU_OUT_BYPASS_EN` defined:
  - When `count == 0` and `in_valid`, `fu_rs` shows `in_packet` with `.valid` = 1 in the same cycle.
  - A grant in that cycle consumes it directly, nothing is written, and `count` stays 0.
  - Without a grant, the result is written normally.
  - Squash suppresses the bypass, so `fu_rs.valid` = 0 in that cycle.
- Macro undefined: no bypass; minimum result-to-`fu_rs` latency is 1 cycle, as described in Timing.

## Structure
- Shared package (`sys_defs`):
  - `FU_RS_PACKET` typedef.
  - `FU_SIZE`, `FU_CAT`.
  - `ALU_OFFSET`, `LS_OFFSET`, `MULT_OFFSET`, `BEQ_OFFSET`.
- Sub-modules:
  - No sub-module is needed for the ring itself; it is written inline in this module.
  - One natural sub-module: `wrap_ptr`, a pointer register with increment, wrap at `DEPTH-1`, and synchronous clear. It is instantiated twice, for `head` and `tail`.

## Test plan
- Reset, then idle for 3 cycles → `fu_rs.valid` = 0, `count` = 0, `in_ready` = 1 throughout.
- `DEPTH` = 2; push A at cycle 1 and B at cycle 2, no grants → cycle 3: `count` = 2, `in_ready` = 0, `fu_rs` = A. Grant at cycle 3 → cycle 4: `fu_rs` = B, `in_ready` = 1.
- Ordering with wrap-around: push C and grant in the same cycle with `count` = 1 → `count` stays 1. Repeat 5 times → outputs appear in push order, pointers wrap with no loss.
- Grant with `fu_num` ≠ `FU_IDX`, and separately a grant while empty → no pop and no state change.
- `count` = 2 plus `squash` with concurrent `in_valid` and grant → next cycle: `count` = 0, `fu_rs.valid` = 0, and the concurrent input never appears.
- `FU_OUT_BYPASS_EN`: empty buffer, `in_valid` with packet D and a same-cycle grant → `fu_rs` = D combinationally and `count` remains 0. Without the macro → D appears one cycle later.

Source files
------------

// File: rtl/sys_defs.sv
// Shared FU/selector definitions.
// Result packet layout and FU slot map.
package sys_defs;

  localparam int FU_SIZE     = 8;
  localparam int FU_CAT      = 4;
  localparam int ALU_OFFSET  = 0;
  localparam int LS_OFFSET   = 3;
  localparam int MULT_OFFSET = 5;
  localparam int BEQ_OFFSET  = 7;
  localparam int FU_NUM_W    = $clog2(FU_SIZE) + 1;

  typedef struct packed {
    logic        valid;
    logic [5:0]  dest_prf;
    logic [4:0]  rob_idx;
    logic        take_branch;
    logic [31:0] result;
  } FU_RS_PACKET;

  // Copy of a packet with its valid bit replaced.
  function automatic FU_RS_PACKET pkt_with_valid(
    input FU_RS_PACKET p,
    input logic        v
  );
    FU_RS_PACKET r;
    r       = p;
    r.valid = v;
    return r;
  endfunction

endpackage

// File: rtl/fu_out_buffer_wrap_ptr.sv
// Ring pointer: increment with wrap at DEPTH-1.
// Synchronous clear shares priority with reset.
module wrap_ptr #(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Advance on inc, wrapping by explicit compare.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fu_out_buffer.sv
// Per-FU in-order result queue feeding the result selector.
// Optional same-cycle bypass: FU_OUT_BYPASS_EN.
module fu_out_buffer
  import sys_defs::*;
#(
  parameter int DEPTH  = 2,
  parameter int FU_IDX = 0,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  FU_RS_PACKET               in_packet,
  output logic                      in_ready,
  input  logic [$clog2(FU_SIZE):0]  fu_num,
  input  logic                      grant_valid,
  input  logic                      squash,
  output FU_RS_PACKET               fu_rs,
  output logic [CW-1:0]             count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [$clog2(FU_SIZE):0] IDX =
    ($clog2(FU_SIZE) + 1)'(FU_IDX);

  FU_RS_PACKET   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          empty;
  logic          hit;
  logic          bypass;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);
  assign hit      = grant_valid && (fu_num == IDX);

`ifdef FU_OUT_BYPASS_EN
  assign bypass = empty && in_valid && !squash && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign push = in_valid && in_ready && !squash && !(bypass && hit);
  assign pop  = hit && !empty && !squash;

  wrap_ptr #(.DEPTH(DEPTH)) u_head (
    .clock (clock),
    .reset (reset),
    .clear (squash),
    .inc   (pop),
    .ptr   (head)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_tail (
    .clock (clock),
    .reset (reset),
    .clear (squash),
    .inc   (push),
    .ptr   (tail)
  );

  // Occupancy tracks push/pop; squash empties the ring.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

  // Result storage; reset clears every entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[tail] <= in_packet;
    end
  end

  // Head entry, or the incoming result when bypassing.
  always_comb begin
    fu_rs = pkt_with_valid(mem[head], !empty);
    if (bypass) begin
      fu_rs = pkt_with_valid(in_packet, 1'b1);
    end
  end

endmodule
